// File: rtl/route_encode_if.sv
// Handshake bundle for route_encode: upstream packet channel in, encoded
// {dir, payload} channel out. slave = the encoder, master = its environment.
interface route_encode_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_dest;
  logic [DATA_W-1:0] in_payload;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_dir;
  logic [DATA_W-1:0] out_payload;

  modport master (
    output in_valid, in_dest, in_payload, out_ready,
    input  in_ready, out_valid, out_dir, out_payload
  );

  modport slave (
    input  in_valid, in_dest, in_payload, out_ready,
    output in_ready, out_valid, out_dir, out_payload
  );
endinterface

// File: rtl/route_encode.sv
// Mesh route encoder: per-axis direction bits, buffered with payload in a 2-entry FIFO.
// Optional per-direction transfer counters are enabled by defining ROUTE_CNT_EN.
module route_encode #(
  parameter logic [3:0] ADDR   = 4'b0000,
  parameter int         DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  route_encode_if.slave     bus
`ifdef ROUTE_CNT_EN
  ,
  output logic [7:0]        cnt_core,
  output logic [7:0]        cnt_p0,
  output logic [7:0]        cnt_p1,
  output logic [7:0]        cnt_p2,
  output logic [7:0]        cnt_p3
`endif
);
  localparam int ENT_W = 4 + DATA_W;

  logic [1:0]       loc_x, loc_y, dst_x, dst_y;
  logic [3:0]       dir_enc;
  logic             push, pop;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [ENT_W-1:0] head;

  assign loc_x = ADDR[1:0];
  assign loc_y = ADDR[3:2];
  assign dst_x = bus.in_dest[1:0];
  assign dst_y = bus.in_dest[3:2];

  // Every productive direction is flagged; the consumer picks the lowest bit.
  assign dir_enc = {dst_y < loc_y, dst_y > loc_y, dst_x < loc_x, dst_x > loc_x};

  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ent
      logic [ENT_W-1:0] entry_q;
      // Entries clear on reset so out_dir/out_payload read zero until the first push.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= '0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          entry_q <= {dir_enc, bus.in_payload};
        end
      end
    end
  endgenerate

  assign head = rd_ptr_q ? g_ent[1].entry_q : g_ent[0].entry_q;
  assign {bus.out_dir, bus.out_payload} = head;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

`ifdef ROUTE_CNT_EN
  logic [3:0] head_dir, low_bit;
  logic [4:0] hit;

  // Isolate the lowest set direction bit; bit 0 of hit stands for local delivery.
  assign head_dir = head[ENT_W-1 -: 4];
  assign low_bit  = head_dir & (~head_dir + 4'd1);
  assign hit      = pop ? {low_bit, head_dir == 4'd0} : 5'd0;

  generate
    for (gi = 0; gi < 5; gi++) begin : g_cnt
      logic [7:0] cnt_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= 8'd0;
        end else if (hit[gi] && (cnt_q != 8'hFF)) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  endgenerate

  assign cnt_core = g_cnt[0].cnt_q;
  assign cnt_p0   = g_cnt[1].cnt_q;
  assign cnt_p1   = g_cnt[2].cnt_q;
  assign cnt_p2   = g_cnt[3].cnt_q;
  assign cnt_p3   = g_cnt[4].cnt_q;
`endif
endmodule

// File: tb/tb_route_encode.sv
// Bench for route_encode: queue-based reference model checked every cycle,
// directed routing/back-pressure/throughput/reset scenarios plus random traffic.
module tb_route_encode;
  localparam logic [3:0] ADDR = 4'b0101;
  localparam int         DW   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  route_encode_if #(.DATA_W(DW)) bus ();

`ifdef ROUTE_CNT_EN
  logic [7:0] cnt_core, cnt_p0, cnt_p1, cnt_p2, cnt_p3;
`endif

  route_encode #(.ADDR(ADDR), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef ROUTE_CNT_EN
    ,
    .cnt_core (cnt_core),
    .cnt_p0   (cnt_p0),
    .cnt_p1   (cnt_p1),
    .cnt_p2   (cnt_p2),
    .cnt_p3   (cnt_p3)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Direction from coordinates: one flag per axis sense in which dest lies.
  function automatic logic [3:0] route_of(input logic [3:0] d);
    int ax, ay, dx, dy;
    ax = int'(ADDR[1:0]); ay = int'(ADDR[3:2]);
    dx = int'(d[1:0]);    dy = int'(d[3:2]);
    return {dy < ay, dy > ay, dx < ax, dx > ax};
  endfunction

  typedef struct packed {
    logic [3:0]    dir;
    logic [DW-1:0] pl;
  } ent_t;

  ent_t model_q[$];
  int   m_cnt[5];
  bit   m_pop, m_push;
  ent_t m_head;
  int   m_k;

  // Reference model: a bounded queue of depth 2 updated on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    end else begin
      m_pop  = (model_q.size() != 0) && bus.out_ready;
      m_push = bus.in_valid && (model_q.size() < 2);
      if (m_pop) begin
        m_head = model_q.pop_front();
        m_k = 0;
        for (int i = 3; i >= 0; i--) if (m_head.dir[i]) m_k = i + 1;
        if (m_cnt[m_k] < 255) m_cnt[m_k]++;
      end
      if (m_push) model_q.push_back({route_of(bus.in_dest), bus.in_payload});
    end
  end

  // Compare process: outputs settled, inputs stable (driven on falling edges).
  always @(posedge clk) begin
    #2;
    check("out_valid", int'(bus.out_valid), int'(model_q.size() != 0));
    check("in_ready",  int'(bus.in_ready),  int'(model_q.size() < 2));
    if (model_q.size() != 0) begin
      check("out_dir",     int'(bus.out_dir),     int'(model_q[0].dir));
      check("out_payload", int'(bus.out_payload), int'(model_q[0].pl));
    end
`ifdef ROUTE_CNT_EN
    check("cnt_core", int'(cnt_core), m_cnt[0]);
    check("cnt_p0",   int'(cnt_p0),   m_cnt[1]);
    check("cnt_p1",   int'(cnt_p1),   m_cnt[2]);
    check("cnt_p2",   int'(cnt_p2),   m_cnt[3]);
    check("cnt_p3",   int'(cnt_p3),   m_cnt[4]);
`endif
  end

  logic [3:0]    dir_dest [4] = '{4'b0101, 4'b1011, 4'b0000, 4'b0100};
  logic [3:0]    dir_want [4] = '{4'b0000, 4'b0101, 4'b1010, 4'b0010};
  logic [DW-1:0] bp_tbl   [3] = '{8'hA1, 8'hB2, 8'hC3};
  logic [DW-1:0] seen[$];
  int idx, acc, pops, stalls;

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_dest    = 4'd0;
    bus.in_payload = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid",   int'(bus.out_valid),   0);
    check("rst_in_ready",    int'(bus.in_ready),    1);
    check("rst_out_dir",     int'(bus.out_dir),     0);
    check("rst_out_payload", int'(bus.out_payload), 0);
    reset = 1'b0;

    // Directed routing cases, each visible one cycle after accept
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.in_dest    = dir_dest[i];
      bus.in_payload = 8'h10 + 8'(i);
      bus.out_ready  = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("dir_valid",   int'(bus.out_valid),   1);
      check("dir_value",   int'(bus.out_dir),     int'(dir_want[i]));
      check("dir_payload", int'(bus.out_payload), 16 + i);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end

    // Back-pressure: A,B fill the FIFO, C waits, then order A,B,C
    idx = 0;
    seen.delete();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bus.in_valid   = (idx < 3);
      bus.in_dest    = 4'b0000;
      bus.in_payload = (idx < 3) ? bp_tbl[idx] : 8'h00;
      bus.out_ready  = (c >= 6);
      if (c == 4) begin
        check("bp_in_ready_full", int'(bus.in_ready),    0);
        check("bp_head_held",     int'(bus.out_payload), int'(bp_tbl[0]));
      end
      if (bus.out_valid && bus.out_ready) seen.push_back(bus.out_payload);
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_count", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      check("bp_order", (i < seen.size()) ? int'(seen[i]) : -1, int'(bp_tbl[i]));

    // Streaming: 10 back-to-back packets with out_ready high
    @(negedge clk);
    bus.out_ready = 1'b1;
    acc = 0; pops = 0; stalls = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bus.in_valid   = (c < 10);
      bus.in_dest    = 4'(c);
      bus.in_payload = 8'(c);
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid && bus.out_ready) pops++;
      if (c < 10 && !bus.in_ready) stalls++;
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", acc, 10);
    check("stream_pops",    pops, 10);
    check("stream_stalls",  stalls, 0);

    // Random traffic with occasional mid-run reset
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset          = ($urandom_range(0, 199) == 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_dest    = 4'($urandom);
      bus.in_payload = 8'($urandom);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset with a full FIFO clears it before the next edge
    bus.in_valid   = 1'b1;
    bus.in_dest    = 4'b0000;
    bus.in_payload = 8'h5A;
    @(negedge clk);
    bus.in_payload = 8'h6B;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("full_in_ready",  int'(bus.in_ready),  0);
    check("full_out_valid", int'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    check("arst_out_valid",   int'(bus.out_valid),   0);
    check("arst_in_ready",    int'(bus.in_ready),    1);
    check("arst_out_dir",     int'(bus.out_dir),     0);
    check("arst_out_payload", int'(bus.out_payload), 0);
    @(negedge clk);
    reset = 1'b0;

`ifdef ROUTE_CNT_EN
    // 300 local packets saturate the core counter
    @(negedge clk);
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_dest    = ADDR;
    bus.in_payload = 8'h33;
    repeat (300) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_cnt_core", int'(cnt_core), 255);
    check("sat_cnt_p0",   int'(cnt_p0),   0);
    check("sat_cnt_p3",   int'(cnt_p3),   0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
